// File: rtl/seq_adder_pkg.sv
// rtl/seq_adder_pkg.sv - shared FSM encoding, defaults and helpers for the chunked adder
package seq_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Chunk index width: enough bits to count NCHUNK chunks, never zero.
    function automatic int idx_width(input int nchunk);
        int w;
        w = $clog2(nchunk);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/chunk_rca.sv
// rtl/chunk_rca.sv - combinational ripple-carry adder for one chunk
module chunk_rca #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic carry_v;

    // Ripple the carry bit by bit; cmsb is the carry entering the top bit,
    // which the top level needs for two's-complement overflow.
    always_comb begin
        carry_v = cin;
        cmsb    = 1'b0;
        sum     = '0;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                cmsb = carry_v;
            end
            sum[i]  = a[i] ^ b[i] ^ carry_v;
            carry_v = (a[i] & b[i]) | (carry_v & (a[i] ^ b[i]));
        end
        cout = carry_v;
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle adder/subtractor processing CHUNK bits per clock
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
    localparam int IW         = idx_width(NCHUNK);

    generate
        if ((CHUNK < 1) || (WIDTH < 2) || ((WIDTH % SAFE_CHUNK) != 0)) begin : g_bad_params
            $error("seq_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
        end
    endgenerate

    state_t state, state_next;

    // Latched operands shift right one chunk per RUN cycle so the active
    // chunk is always in the low CHUNK bits.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [IW-1:0]    idx;

    logic             accept;
    logic             last;

    logic [CHUNK-1:0] c_sum;
    logic             c_out;
    logic             c_msb;

    // Result chunks enter at the top and move down, so after NCHUNK cycles
    // chunk idx sits at sum[idx*CHUNK +: CHUNK].
    logic [WIDTH+CHUNK-1:0] sum_cat;
    logic [WIDTH-1:0]       sum_next;

    assign accept   = start && (state != ST_RUN);
    assign last     = (state == ST_RUN) && (idx == IW'(NCHUNK - 1));
    assign sum_cat  = {c_sum, sum};
    assign sum_next = sum_cat[WIDTH+CHUNK-1:CHUNK];

    chunk_rca #(
        .W(CHUNK)
    ) u_rca (
        .a   (op_a[CHUNK-1:0]),
        .b   (op_b[CHUNK-1:0]),
        .cin (carry),
        .sum (c_sum),
        .cout(c_out),
        .cmsb(c_msb)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured outside RUN.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_next = last ? ST_DONE : ST_RUN;
            ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded straight from the state.
    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // Datapath: latch on accept, add one chunk per RUN cycle, flags on the last chunk.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
        end else if (state == ST_RUN) begin
            op_a  <= op_a >> CHUNK;
            op_b  <= op_b >> CHUNK;
            carry <= c_out;
            idx   <= idx + IW'(1);
            sum   <= sum_next;
            if (last) begin
                cout <= c_out;
                ovf  <= c_out ^ c_msb;
            end
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - self-checking bench for seq_chunk_adder
module tb_seq_chunk_adder;

    logic        clock;
    logic        reset;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];

    seq_chunk_adder #(
        .WIDTH(32),
        .CHUNK(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the operands, sign rules for overflow.
    function automatic logic [33:0] ref_model(input logic s, input logic [31:0] xa,
                                              input logic [31:0] xb, input logic xc);
        logic [32:0] full;
        logic        v;
        if (s) begin
            full = {1'b0, xa} + {1'b0, ~xb} + 33'd1;
            v    = (xa[31] != xb[31]) && (full[31] != xa[31]);
        end else begin
            full = {1'b0, xa} + {1'b0, xb} + {32'd0, xc};
            v    = (xa[31] == xb[31]) && (full[31] != xa[31]);
        end
        return {v, full[32], full[31:0]};
    endfunction

    // Wait for done after the accept edge; returns edges counted, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_op(input string nm, input logic s, input logic [31:0] xa,
                         input logic [31:0] xb, input logic xc, input logic [31:0] es,
                         input logic ec, input logic eo);
        int          cyc;
        logic [31:0] held;
        sub   = s;
        a     = xa;
        b     = xb;
        cin   = xc;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sub   = 1'($urandom);
        cin   = 1'($urandom);
        check({nm, " busy"}, {63'd0, busy}, 64'd1);
        wait_done(cyc);
        check({nm, " latency"}, 64'(cyc), 64'd4);
        check({nm, " sum"}, {32'd0, sum}, {32'd0, es});
        check({nm, " cout/ovf"}, {62'd0, cout, ovf}, {62'd0, ec, eo});
        held = sum;
        tick();
        check({nm, " done one cycle"}, {62'd0, done, busy}, 64'd0);
        check({nm, " sum hold"}, {32'd0, sum}, {32'd0, held});
    endtask

    initial begin
        int          cyc;
        int          pulses;
        logic [33:0] r;
        logic [31:0] ra, rb;
        logic        rs, rc;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h00000007, 32'h00000005, 1'b0, 32'h00000002, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h00000003, 32'h00000003, 1'b0, 32'h00000000, 1'b1, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("reset state", {29'd0, busy, done, cout, ovf, sum}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin,
                  vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            rc = 1'($urandom);
            if (i < 4) rb = ~ra;
            r = ref_model(rs, ra, rb, rc);
            do_op($sformatf("rand%0d", i), rs, ra, rb, rc, r[31:0], r[32], r[33]);
        end

        // Start pulsed mid-RUN with different operands must be ignored.
        sub = 1'b0; a = 32'h00000010; b = 32'h00000020; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        sub = 1'b1; a = 32'hDEADBEEF; b = 32'h12345678; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 2;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("ignore latency", 64'(cyc), 64'd4);
        check("ignore sum", {32'd0, sum}, 64'h30);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) pulses++;
        end
        check("ignore extra done", 64'(pulses), 64'd0);

        // Reset two cycles into RUN aborts with no done pulse.
        sub = 1'b0; a = 32'hFFFFFF00; b = 32'h00000100; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("reset abort outputs", {29'd0, busy, done, cout, ovf, sum}, 64'd0);
        tick();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("reset abort no done", 64'(pulses), 64'd0);
        r = ref_model(1'b0, 32'hFFFFFF00, 32'h00000100, 1'b1);
        do_op("after reset", 1'b0, 32'hFFFFFF00, 32'h00000100, 1'b1, r[31:0], r[32], r[33]);

        // Start held across DONE: back-to-back with no IDLE cycle.
        sub = 1'b0; a = 32'h00000001; b = 32'h00000002; cin = 1'b0; start = 1'b1;
        tick();
        sub = 1'b1; a = 32'h00001000; b = 32'h00000001; cin = 1'b1;
        wait_done(cyc);
        check("b2b first latency", 64'(cyc), 64'd4);
        check("b2b first sum", {32'd0, sum}, 64'h3);
        tick();
        start = 1'b0;
        check("b2b no idle", {62'd0, busy, done}, 64'd2);
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("b2b spacing", 64'(cyc), 64'd5);
        check("b2b second sum", {32'd0, sum}, 64'h00000FFF);
        check("b2b second cout/ovf", {62'd0, cout, ovf}, 64'd2);
        tick();
        check("b2b idle", {62'd0, busy, done}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
